// File: rtl/seq_pkg.sv
// Shared definitions for the serial scan controller and its bench.
// Holds the controller state encoding, default widths and the pattern
// recognised by the neighbouring fsm_detector ("10001", MSB first).
package seq_pkg;

  localparam int unsigned DEF_WORD_W = 16;
  localparam int unsigned DEF_CNT_W  = 5;

  // Serial pattern the detector ticks on; the last '1' is the tick bit.
  localparam logic [4:0] DET_PATTERN = 5'b10001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / result-out handshake bundle of seq_scan_ctrl.
//  in_valid/in_ready/in_data            : word source -> controller
//  out_valid/out_ready/out_count/mask   : controller -> result sink
// master = source/sink side, slave = controller side.
interface seq_scan_ctrl_if
  import seq_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [WORD_W-1:0] out_hit_mask;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_hit_mask
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_hit_mask
  );

endinterface

// File: rtl/fsm_detector.sv
// Serial overlapping "10001" detector (Mealy).
//  clk, reset   : clock, async active-high reset (holds state A)
//  sequence_in  : serial input bit
//  tick         : combinational, high in the cycle the closing '1' is on sequence_in
module fsm_detector (
  input  logic clk,
  input  logic reset,
  input  logic sequence_in,
  output logic tick
);

  // A: nothing, B: "1", C: "10", D: "100", E: "1000"
  typedef enum logic [2:0] {
    DS_A = 3'd0,
    DS_B = 3'd1,
    DS_C = 3'd2,
    DS_D = 3'd3,
    DS_E = 3'd4
  } det_state_e;

  det_state_e state_q, state_d;

  // Any '1' restarts at B (overlap); zeros walk C -> D -> E, a fourth zero falls back to A
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_A:    state_d = sequence_in ? DS_B : DS_A;
      DS_B:    state_d = sequence_in ? DS_B : DS_C;
      DS_C:    state_d = sequence_in ? DS_B : DS_D;
      DS_D:    state_d = sequence_in ? DS_B : DS_E;
      DS_E:    state_d = sequence_in ? DS_B : DS_A;
      default: state_d = DS_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DS_A;
    end else begin
      state_q <= state_d;
    end
  end

  assign tick = (state_q == DS_E) & sequence_in;

endmodule

// File: rtl/seq_piso.sv
// Loadable MSB-first parallel-in/serial-out shift register.
//  clk, reset  : clock, async active-high reset
//  load        : capture load_data, bit_idx <= WORD_W-1 (wins over shift)
//  shift       : shift left by one, bit_idx decrements (stops at 0)
//  msb         : current serial bit (register MSB)
//  bit_idx     : original word position of the bit currently on msb
//  last        : bit_idx == 0
module seq_piso #(
  parameter int unsigned WORD_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      shift,
  input  logic [WORD_W-1:0]         load_data,
  output logic                      msb,
  output logic [$clog2(WORD_W)-1:0] bit_idx,
  output logic                      last
);

  localparam int unsigned IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Next shift register / index
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load) begin
      shreg_d = load_data;
      idx_d   = IDX_W'(WORD_W - 1);
    end else if (shift) begin
      shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
      if (idx_q != '0) begin
        idx_d = idx_q - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign msb     = shreg_q[WORD_W-1];
  assign bit_idx = idx_q;
  assign last    = (idx_q == '0);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Feeds parallel words MSB-first into the serial "10001" detector, owns the
// detector reset and returns per-word tick count and hit mask.
//  clk, reset  : clock, async active-high reset
//  bus (slave) : in_valid/in_ready/in_data word source,
//                out_valid/out_ready/out_count/out_hit_mask result sink
//  det_seq     : serial bit to detector
//  det_clr     : detector reset, high whenever the FSM is not in SHIFT
//  det_tick    : detector tick for the current det_seq bit
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  seq_scan_ctrl_if.slave bus,
  output logic           det_seq,
  output logic           det_clr,
  input  logic           det_tick
);

  localparam int unsigned      IDX_W   = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] mask_q, mask_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic [WORD_W-1:0] out_mask_q, out_mask_d;
  logic              det_clr_q, det_clr_d;
  logic              in_ready_q, in_ready_d;

  logic              shifting, last_bit, slot_free, in_ready_c, accept, tick_v;
  logic              piso_msb, piso_last;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  count_inc;
  logic [WORD_W-1:0] mask_inc;

  seq_piso #(.WORD_W(WORD_W)) u_piso (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .shift     (shifting),
    .load_data (bus.in_data),
    .msb       (piso_msb),
    .bit_idx   (bit_idx),
    .last      (piso_last)
  );

  // Handshake and per-bit accumulation; the registered in_ready covers IDLE,
  // the combinational term lets a new word follow the last bit with no bubble.
  always_comb begin
    shifting   = (state_q == ST_SHIFT);
    last_bit   = shifting & piso_last;
    slot_free  = ~out_valid_q | bus.out_ready;
    in_ready_c = in_ready_q | (last_bit & slot_free);
    accept     = bus.in_valid & in_ready_c;
    tick_v     = shifting & det_tick;
    count_inc  = (tick_v && (count_q != CNT_MAX)) ? count_q + CNT_W'(1) : count_q;
    mask_inc   = mask_q;
    if (tick_v) begin
      mask_inc = mask_q | (WORD_W'(1) << bit_idx);
    end
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_mask_d  = out_mask_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          count_d = '0;
          mask_d  = '0;
        end
      end
      ST_SHIFT: begin
        count_d = count_inc;
        mask_d  = mask_inc;
        if (last_bit) begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_count_d = count_inc;
            out_mask_d  = mask_inc;
            if (accept) begin
              state_d = ST_SHIFT;
              count_d = '0;
              mask_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            // Sink still full: park the finished result internally
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b1;
          out_count_d = count_q;
          out_mask_d  = mask_q;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    det_clr_d  = (state_d != ST_SHIFT);
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_mask_q  <= '0;
      det_clr_q   <= 1'b1;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_mask_q  <= out_mask_d;
      det_clr_q   <= det_clr_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_hit_mask = out_mask_q;
  assign det_seq          = piso_msb;
  assign det_clr          = det_clr_q;

endmodule
